// File: rtl/ascon128_aead_ctrl_if.sv
// Bundle of the host-side streaming signals and the permutation-unit
// handshake for the Ascon-128 AEAD controller.
// The slave modport is the controller's view; the master modport is the
// surrounding encrypt top level / permutation core.
// Optional macro ASCON_DECRYPT_EN adds the decrypt mode select.
interface ascon128_aead_ctrl_if;
    logic         start;
    logic         has_ad;
    logic [127:0] key;
    logic [127:0] nonce;
`ifdef ASCON_DECRYPT_EN
    logic         decrypt;
`endif
    logic         ad_valid;
    logic         ad_ready;
    logic [63:0]  ad_data;
    logic         ad_last;
    logic         pt_valid;
    logic         pt_ready;
    logic [63:0]  pt_data;
    logic         pt_last;
    logic         ct_valid;
    logic         ct_ready;
    logic [63:0]  ct_data;
    logic [127:0] tag;
    logic         tag_valid;
    logic         busy;
    logic         perm_start;
    logic [3:0]   perm_rounds;
    logic [319:0] perm_state_in;
    logic [319:0] perm_state_out;
    logic         perm_done;

    modport slave (
        input  start, has_ad, key, nonce,
`ifdef ASCON_DECRYPT_EN
        input  decrypt,
`endif
        input  ad_valid, ad_data, ad_last,
        input  pt_valid, pt_data, pt_last,
        input  ct_ready, perm_state_out, perm_done,
        output ad_ready, pt_ready, ct_valid, ct_data,
        output tag, tag_valid, busy,
        output perm_start, perm_rounds, perm_state_in
    );

    modport master (
        output start, has_ad, key, nonce,
`ifdef ASCON_DECRYPT_EN
        output decrypt,
`endif
        output ad_valid, ad_data, ad_last,
        output pt_valid, pt_data, pt_last,
        output ct_ready, perm_state_out, perm_done,
        input  ad_ready, pt_ready, ct_valid, ct_data,
        input  tag, tag_valid, busy,
        input  perm_start, perm_rounds, perm_state_in
    );
endinterface

// File: rtl/ascon128_aead_ctrl.sv
// Ascon-128 AEAD sequencing controller. Owns the 320-bit state (x0..x4,
// x0 in the top 64 bits), applies all IV/key/data/domain XORs and drives an
// external round-permutation unit through a start/done handshake.
// Optional macro ASCON_DECRYPT_EN: adds decrypt mode (io.decrypt, sampled
// with start). In decrypt mode pt_data carries ciphertext, ct_data returns
// x0 ^ pt_data and x0 is replaced by pt_data.
module ascon128_aead_ctrl #(
    parameter logic [3:0]  ROUNDS_A = 4'd12,
    parameter logic [3:0]  ROUNDS_B = 4'd6,
    parameter logic [63:0] IV       = 64'h80400c0600000000
) (
    input  logic                 CLK,
    input  logic                 RST,
    ascon128_aead_ctrl_if.slave  io
);
    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        INIT    = 4'd1,
        AD_WAIT = 4'd2,
        AD_PERM = 4'd3,
        DSEP    = 4'd4,
        PT_WAIT = 4'd5,
        PT_PERM = 4'd6,
        FIN     = 4'd7,
        DONE    = 4'd8
    } state_t;

    state_t        state_r, state_s;
    logic [319:0]  s_r, s_s;
    logic [127:0]  key_r, key_s;
    logic          has_ad_r, has_ad_s;
    logic          ad_last_r, ad_last_s;
    logic          ad_ready_r, ad_ready_s;
    logic          pt_ready_r, pt_ready_s;
    logic          ct_valid_r, ct_valid_s;
    logic [63:0]   ct_data_r, ct_data_s;
    logic [127:0]  tag_r, tag_s;
    logic          tag_valid_r, tag_valid_s;
    logic          busy_r, busy_s;
    logic          perm_start_r, perm_start_s;
    logic [3:0]    perm_rounds_r, perm_rounds_s;
`ifdef ASCON_DECRYPT_EN
    logic          decrypt_r, decrypt_s;
`endif

    logic [63:0]   x0_s;
    logic [63:0]   xored_s;
    logic [63:0]   new_x0_s;
    logic          perm_ack_s;

    assign x0_s    = s_r[319:256];
    // ct_data is x0 ^ input in both directions; only the state update differs
    assign xored_s = x0_s ^ io.pt_data;
`ifdef ASCON_DECRYPT_EN
    assign new_x0_s = decrypt_r ? io.pt_data : xored_s;
`else
    assign new_x0_s = xored_s;
`endif
    // a done pulse in the same cycle as our own request cannot belong to it
    assign perm_ack_s = io.perm_done & ~perm_start_r;

    assign io.ad_ready      = ad_ready_r;
    assign io.pt_ready      = pt_ready_r;
    assign io.ct_valid      = ct_valid_r;
    assign io.ct_data       = ct_data_r;
    assign io.tag           = tag_r;
    assign io.tag_valid     = tag_valid_r;
    assign io.busy          = busy_r;
    assign io.perm_start    = perm_start_r;
    assign io.perm_rounds   = perm_rounds_r;
    assign io.perm_state_in = s_r;

    // Next-state and next-register computation for the sequencing FSM
    always_comb begin
        state_s       = state_r;
        s_s           = s_r;
        key_s         = key_r;
        has_ad_s      = has_ad_r;
        ad_last_s     = ad_last_r;
        ad_ready_s    = ad_ready_r;
        pt_ready_s    = pt_ready_r;
        ct_data_s     = ct_data_r;
        tag_s         = tag_r;
        tag_valid_s   = tag_valid_r;
        busy_s        = busy_r;
        perm_start_s  = 1'b0;
        perm_rounds_s = perm_rounds_r;
`ifdef ASCON_DECRYPT_EN
        decrypt_s     = decrypt_r;
`endif
        // a pending ciphertext beat retires independently of the FSM
        if (ct_valid_r && io.ct_ready) begin
            ct_valid_s = 1'b0;
        end else begin
            ct_valid_s = ct_valid_r;
        end

        case (state_r)
            IDLE, DONE: begin
                if (io.start) begin
                    s_s           = {IV, io.key, io.nonce};
                    key_s         = io.key;
                    has_ad_s      = io.has_ad;
`ifdef ASCON_DECRYPT_EN
                    decrypt_s     = io.decrypt;
`endif
                    tag_valid_s   = 1'b0;
                    busy_s        = 1'b1;
                    perm_start_s  = 1'b1;
                    perm_rounds_s = ROUNDS_A;
                    state_s       = INIT;
                end else begin
                    state_s = state_r;
                end
            end
            INIT: begin
                if (perm_ack_s) begin
                    s_s = io.perm_state_out ^ {192'd0, key_r};
                    if (has_ad_r) begin
                        ad_ready_s = 1'b1;
                        state_s    = AD_WAIT;
                    end else begin
                        state_s = DSEP;
                    end
                end else begin
                    state_s = INIT;
                end
            end
            AD_WAIT: begin
                if (io.ad_valid && ad_ready_r) begin
                    s_s[319:256]  = x0_s ^ io.ad_data;
                    ad_last_s     = io.ad_last;
                    ad_ready_s    = 1'b0;
                    perm_start_s  = 1'b1;
                    perm_rounds_s = ROUNDS_B;
                    state_s       = AD_PERM;
                end else begin
                    ad_ready_s = ad_ready_r;
                end
            end
            AD_PERM: begin
                if (perm_ack_s) begin
                    s_s = io.perm_state_out;
                    if (ad_last_r) begin
                        state_s = DSEP;
                    end else begin
                        ad_ready_s = 1'b1;
                        state_s    = AD_WAIT;
                    end
                end else begin
                    state_s = AD_PERM;
                end
            end
            DSEP: begin
                s_s[0]     = ~s_r[0];
                pt_ready_s = ~ct_valid_s;
                state_s    = PT_WAIT;
            end
            PT_WAIT: begin
                if (io.pt_valid && pt_ready_r) begin
                    s_s[319:256] = new_x0_s;
                    ct_data_s    = xored_s;
                    ct_valid_s   = 1'b1;
                    pt_ready_s   = 1'b0;
                    perm_start_s = 1'b1;
                    if (io.pt_last) begin
                        // finalization key XOR is folded into the last transfer
                        // so the permutation sees it on its request cycle
                        s_s[255:128]  = s_r[255:128] ^ key_r;
                        perm_rounds_s = ROUNDS_A;
                        state_s       = FIN;
                    end else begin
                        perm_rounds_s = ROUNDS_B;
                        state_s       = PT_PERM;
                    end
                end else begin
                    pt_ready_s = ~ct_valid_s;
                end
            end
            PT_PERM: begin
                if (perm_ack_s) begin
                    s_s        = io.perm_state_out;
                    pt_ready_s = ~ct_valid_s;
                    state_s    = PT_WAIT;
                end else begin
                    state_s = PT_PERM;
                end
            end
            FIN: begin
                if (perm_ack_s) begin
                    s_s         = io.perm_state_out;
                    tag_s       = io.perm_state_out[127:0] ^ key_r;
                    tag_valid_s = 1'b1;
                    busy_s      = 1'b0;
                    state_s     = DONE;
                end else begin
                    state_s = FIN;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, datapath and output registers with asynchronous clear
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r       <= IDLE;
            s_r           <= 320'd0;
            key_r         <= 128'd0;
            has_ad_r      <= 1'b0;
            ad_last_r     <= 1'b0;
            ad_ready_r    <= 1'b0;
            pt_ready_r    <= 1'b0;
            ct_valid_r    <= 1'b0;
            ct_data_r     <= 64'd0;
            tag_r         <= 128'd0;
            tag_valid_r   <= 1'b0;
            busy_r        <= 1'b0;
            perm_start_r  <= 1'b0;
            perm_rounds_r <= 4'd0;
`ifdef ASCON_DECRYPT_EN
            decrypt_r     <= 1'b0;
`endif
        end else begin
            state_r       <= state_s;
            s_r           <= s_s;
            key_r         <= key_s;
            has_ad_r      <= has_ad_s;
            ad_last_r     <= ad_last_s;
            ad_ready_r    <= ad_ready_s;
            pt_ready_r    <= pt_ready_s;
            ct_valid_r    <= ct_valid_s;
            ct_data_r     <= ct_data_s;
            tag_r         <= tag_s;
            tag_valid_r   <= tag_valid_s;
            busy_r        <= busy_s;
            perm_start_r  <= perm_start_s;
            perm_rounds_r <= perm_rounds_s;
`ifdef ASCON_DECRYPT_EN
            decrypt_r     <= decrypt_s;
`endif
        end
    end
endmodule

// File: tb/tb_ascon128_aead_ctrl.sv
// Self-checking bench for ascon128_aead_ctrl. Contains a behavioural Ascon
// permutation unit (fixed latency) and a reference Ascon-128 flow; the
// reference is anchored by the published KAT count 1 tag.
module tb_ascon128_aead_ctrl;
    localparam logic [127:0] KAT_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KAT_TAG = 128'he355159f292911f794cb1432a0103a8a;
    localparam logic [63:0]  IV_W    = 64'h80400c0600000000;
    localparam logic [3:0]   SEQ3 [5] = '{4'd12, 4'd6, 4'd6, 4'd6, 4'd12};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ascon128_aead_ctrl_if bus ();
    ascon128_aead_ctrl dut (.CLK(clk), .RST(rst), .io(bus.slave));

    int checks = 0;
    int errors = 0;

    logic [127:0] key_v, nonce_v, got_tag, exp_tag, three_tag;
    logic [63:0]  ad_blk [4];
    logic [63:0]  pt_blk [4];
    logic [63:0]  got_ct [4];
    logic [63:0]  exp_ct [4];
    logic [63:0]  three_ct [4];
    int           n_got;
    bit           timed_out;
    logic         tv_after_start, busy_after_start, busy_at_tag;
    logic         spur_done;

    function automatic logic [63:0] ror(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [319:0] ascon_p(input logic [319:0] st, input int rounds);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        {x0, x1, x2, x3, x4} = st;
        for (int i = 12 - rounds; i < 12; i++) begin
            x2 = x2 ^ {56'd0, 4'(15 - i), 4'(i)};
            x0 ^= x4; x4 ^= x3; x2 ^= x1;
            t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
            x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
            x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
            x0 ^= ror(x0, 19) ^ ror(x0, 28);
            x1 ^= ror(x1, 61) ^ ror(x1, 39);
            x2 ^= ror(x2, 1)  ^ ror(x2, 6);
            x3 ^= ror(x3, 10) ^ ror(x3, 17);
            x4 ^= ror(x4, 7)  ^ ror(x4, 41);
        end
        return {x0, x1, x2, x3, x4};
    endfunction

    // Reference Ascon-128 encryption over pre-padded blocks
    task automatic gold(input int n_ad, input int n_pt);
        logic [319:0] s;
        s = ascon_p({IV_W, key_v, nonce_v}, 12);
        s[127:0] = s[127:0] ^ key_v;
        for (int i = 0; i < n_ad; i++) begin
            s[319:256] = s[319:256] ^ ad_blk[i];
            s = ascon_p(s, 6);
        end
        s[0] = ~s[0];
        for (int i = 0; i < n_pt; i++) begin
            s[319:256] = s[319:256] ^ pt_blk[i];
            exp_ct[i] = s[319:256];
            if (i < n_pt - 1) s = ascon_p(s, 6);
        end
        s[255:128] = s[255:128] ^ key_v;
        s = ascon_p(s, 12);
        exp_tag = s[127:0] ^ key_v;
    endtask

    // Behavioural permutation unit: fixed latency, logs every request
    logic [319:0] pm_state, model_out;
    logic [3:0]   pm_rounds;
    int           pm_cnt;
    logic         pm_busy, model_done;
    int           perm_overlap = 0;
    logic [3:0]   perm_log [$];
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pm_busy    <= 1'b0;
            model_done <= 1'b0;
            pm_cnt     <= 0;
            model_out  <= 320'd0;
        end else begin
            model_done <= 1'b0;
            if (bus.perm_start) begin
                if (pm_busy) perm_overlap <= perm_overlap + 1;
                pm_busy   <= 1'b1;
                pm_state  <= bus.perm_state_in;
                pm_rounds <= bus.perm_rounds;
                pm_cnt    <= 2;
                perm_log.push_back(bus.perm_rounds);
            end else if (pm_busy) begin
                if (pm_cnt == 0) begin
                    model_done <= 1'b1;
                    model_out  <= ascon_p(pm_state, int'(pm_rounds));
                    pm_busy    <= 1'b0;
                end else begin
                    pm_cnt <= pm_cnt - 1;
                end
            end
        end
    end
    assign bus.perm_done      = model_done | spur_done;
    assign bus.perm_state_out = model_out;

    // Drive one full message and collect ciphertext beats and the tag
    task automatic run_msg(input bit has_ad, input int n_ad, input int n_pt, input bit dec,
                           input bit bp, input bit spur, input bit sbusy);
        int ad_i, pt_i, bp_cnt, cyc;
        bit got_tag_f, spur_used;
        logic [63:0] held;
        ad_i = 0; pt_i = 0; bp_cnt = 0; cyc = 0; n_got = 0;
        got_tag_f = 1'b0; spur_used = 1'b0; timed_out = 1'b0; held = 64'd0;
        @(negedge clk);
        bus.start = 1'b1; bus.has_ad = has_ad; bus.key = key_v; bus.nonce = nonce_v;
`ifdef ASCON_DECRYPT_EN
        bus.decrypt = dec;
`endif
        @(negedge clk);
        bus.start = 1'b0; bus.key = 128'd0; bus.nonce = 128'd0;
        tv_after_start = bus.tag_valid;
        busy_after_start = bus.busy;
        while (!(got_tag_f && n_got >= n_pt) && cyc < 1000) begin
            if (bus.tag_valid && !got_tag_f) begin
                got_tag_f = 1'b1; got_tag = bus.tag; busy_at_tag = bus.busy;
            end
            bus.ad_valid = (ad_i < n_ad);
            bus.ad_data  = ad_blk[ad_i % 4];
            bus.ad_last  = (ad_i == n_ad - 1);
            bus.pt_valid = (pt_i < n_pt);
            bus.pt_data  = pt_blk[pt_i % 4];
            bus.pt_last  = (pt_i == n_pt - 1);
            if (bp && bp_cnt < 20 && bus.ct_valid && n_got == 0) begin
                bus.ct_ready = 1'b0;
                if (bp_cnt == 0) held = bus.ct_data;
                checks++;
                if (bus.ct_valid !== 1'b1 || bus.ct_data !== held || bus.pt_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_hold cyc %0d: ct_valid=%b ct_data=%h pt_ready=%b, required 1 %h 0",
                             bp_cnt, bus.ct_valid, bus.ct_data, bus.pt_ready, held);
                end
                bp_cnt++;
            end else begin
                bus.ct_ready = 1'b1;
            end
            if (spur && !spur_used && bus.pt_ready && pt_i == 1) begin
                spur_done = 1'b1; spur_used = 1'b1;
            end else begin
                spur_done = 1'b0;
            end
            if (sbusy && cyc == 3) begin
                bus.start = 1'b1; bus.key = ~key_v; bus.nonce = ~nonce_v; bus.has_ad = ~has_ad;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.ct_valid && bus.ct_ready) begin
                if (n_got < 4) got_ct[n_got] = bus.ct_data;
                n_got++;
            end
            if (bus.ad_valid && bus.ad_ready) ad_i++;
            if (bus.pt_valid && bus.pt_ready) pt_i++;
            cyc++;
            @(negedge clk);
        end
        bus.ad_valid = 1'b0; bus.pt_valid = 1'b0; spur_done = 1'b0; bus.start = 1'b0;
        if (!(got_tag_f && n_got >= n_pt)) begin
            timed_out = 1'b1;
            checks++; errors++;
            $display("FAIL run_timeout: tag_seen=%b ct_beats=%0d, required 1 %0d", got_tag_f, n_got, n_pt);
        end
    endtask

    task automatic check_zero_outputs(input string name);
        checks++;
        if ({bus.ad_ready, bus.pt_ready, bus.ct_valid, bus.tag_valid, bus.busy, bus.perm_start} !== 6'b0 ||
            bus.ct_data !== 64'd0 || bus.tag !== 128'd0 || bus.perm_state_in !== 320'd0) begin
            errors++;
            $display("FAIL %s: ctl=%b ct_data=%h tag=%h, required all 0", name,
                     {bus.ad_ready, bus.pt_ready, bus.ct_valid, bus.tag_valid, bus.busy, bus.perm_start},
                     bus.ct_data, bus.tag);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset_asserted");
        rst = 1'b1;
        @(negedge clk);
        check_zero_outputs("reset_released_idle");
    endtask

    task automatic test_kat;
        int base;
        key_v = KAT_KEY; nonce_v = KAT_KEY; pt_blk[0] = 64'h8000000000000000;
        gold(0, 1);
        base = perm_log.size();
        run_msg(1'b0, 0, 1, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (n_got !== 1) begin errors++; $display("FAIL kat_beats: got %0d, required 1", n_got); end
        checks++;
        if (got_ct[0] !== exp_ct[0]) begin errors++; $display("FAIL kat_ct: got %h, required %h", got_ct[0], exp_ct[0]); end
        checks++;
        if (got_tag !== KAT_TAG) begin errors++; $display("FAIL kat_tag: got %h, required %h", got_tag, KAT_TAG); end
        checks++;
        if (busy_at_tag !== 1'b0) begin errors++; $display("FAIL kat_busy: got %b, required 0", busy_at_tag); end
        checks++;
        if (perm_log.size() - base != 2 || perm_log[base] !== 4'd12 || perm_log[base + 1] !== 4'd12) begin
            errors++; $display("FAIL kat_rounds: %0d requests, required 2 of 12", perm_log.size() - base);
        end
    endtask

    task automatic load_three;
        key_v = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        nonce_v = 128'hf0e1d2c3b4a5968778695a4b3c2d1e0f;
        ad_blk[0] = 64'h0001020304050680;
        pt_blk[0] = 64'h0001020304050607;
        pt_blk[1] = 64'h08090a0b0c0d0e0f;
        pt_blk[2] = 64'h8000000000000000;
        gold(1, 3);
    endtask

    task automatic test_three_block;
        int base;
        bit ok;
        load_three();
        base = perm_log.size();
        run_msg(1'b1, 1, 3, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (got_ct[i] !== exp_ct[i]) begin errors++; $display("FAIL three_ct%0d: got %h, required %h", i, got_ct[i], exp_ct[i]); end
            three_ct[i] = exp_ct[i];
        end
        three_tag = exp_tag;
        checks++;
        if (got_tag !== exp_tag) begin errors++; $display("FAIL three_tag: got %h, required %h", got_tag, exp_tag); end
        ok = (perm_log.size() - base == 5);
        for (int i = 0; i < 5 && ok; i++) if (perm_log[base + i] !== SEQ3[i]) ok = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL three_rounds: %0d requests, required 12,6,6,6,12", perm_log.size() - base); end
        checks++;
        if (perm_overlap != 0) begin errors++; $display("FAIL perm_overlap: got %0d, required 0", perm_overlap); end
    endtask

    task automatic test_backpressure;
        load_three();
        run_msg(1'b1, 1, 3, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (n_got !== 3) begin errors++; $display("FAIL bp_beats: got %0d, required 3", n_got); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (got_ct[i] !== exp_ct[i]) begin errors++; $display("FAIL bp_ct%0d: got %h, required %h", i, got_ct[i], exp_ct[i]); end
        end
        checks++;
        if (got_tag !== exp_tag) begin errors++; $display("FAIL bp_tag: got %h, required %h", got_tag, exp_tag); end
    endtask

    task automatic test_tag_hold_back_to_back;
        repeat (5) @(negedge clk);
        checks++;
        if (bus.tag_valid !== 1'b1 || bus.tag !== three_tag) begin
            errors++; $display("FAIL tag_hold: valid=%b tag=%h, required 1 %h", bus.tag_valid, bus.tag, three_tag);
        end
        key_v = KAT_KEY; nonce_v = KAT_KEY; pt_blk[0] = 64'h8000000000000000;
        run_msg(1'b0, 0, 1, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (tv_after_start !== 1'b0 || busy_after_start !== 1'b1) begin
            errors++; $display("FAIL restart_flags: tag_valid=%b busy=%b, required 0 1", tv_after_start, busy_after_start);
        end
        checks++;
        if (got_tag !== KAT_TAG) begin errors++; $display("FAIL b2b_tag: got %h, required %h", got_tag, KAT_TAG); end
    endtask

    task automatic test_reset_mid_ad_perm;
        bit seen;
        seen = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.has_ad = 1'b1; bus.key = KAT_KEY; bus.nonce = KAT_KEY;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            bus.ad_valid = 1'b1; bus.ad_data = 64'h8000000000000000; bus.ad_last = 1'b1;
            if (bus.ad_ready) seen = 1'b1;
            @(negedge clk);
        end
        bus.ad_valid = 1'b0;
        checks++;
        if (!seen || bus.perm_start !== 1'b1 || bus.perm_rounds !== 4'd6) begin
            errors++; $display("FAIL ad_perm_request: seen=%b perm_start=%b rounds=%0d, required 1 1 6",
                               seen, bus.perm_start, bus.perm_rounds);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_zero_outputs("reset_mid_ad_perm");
        @(negedge clk);
        rst = 1'b1;
        key_v = KAT_KEY; nonce_v = KAT_KEY; pt_blk[0] = 64'h8000000000000000;
        run_msg(1'b0, 0, 1, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (got_tag !== KAT_TAG) begin errors++; $display("FAIL post_reset_tag: got %h, required %h", got_tag, KAT_TAG); end
    endtask

    task automatic test_busy_start_spurious;
        load_three();
        run_msg(1'b1, 1, 3, 1'b0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (got_tag !== three_tag) begin errors++; $display("FAIL ignore_tag: got %h, required %h", got_tag, three_tag); end
        checks++;
        if (got_ct[2] !== three_ct[2] || n_got !== 3) begin
            errors++; $display("FAIL ignore_ct: got %h beats %0d, required %h 3", got_ct[2], n_got, three_ct[2]);
        end
    endtask

`ifdef ASCON_DECRYPT_EN
    task automatic test_decrypt;
        logic [63:0] orig [3];
        load_three();
        for (int i = 0; i < 3; i++) begin orig[i] = pt_blk[i]; pt_blk[i] = three_ct[i]; end
        run_msg(1'b1, 1, 3, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (got_ct[i] !== orig[i]) begin errors++; $display("FAIL dec_pt%0d: got %h, required %h", i, got_ct[i], orig[i]); end
        end
        checks++;
        if (got_tag !== three_tag) begin errors++; $display("FAIL dec_tag: got %h, required %h", got_tag, three_tag); end
    endtask
`endif

    initial begin
        rst = 1'b0;
        spur_done = 1'b0;
        bus.start = 1'b0; bus.has_ad = 1'b0; bus.key = 128'd0; bus.nonce = 128'd0;
`ifdef ASCON_DECRYPT_EN
        bus.decrypt = 1'b0;
`endif
        bus.ad_valid = 1'b0; bus.ad_data = 64'd0; bus.ad_last = 1'b0;
        bus.pt_valid = 1'b0; bus.pt_data = 64'd0; bus.pt_last = 1'b0;
        bus.ct_ready = 1'b1;
        test_reset();
        test_kat();
        test_three_block();
        test_backpressure();
        test_tag_hold_back_to_back();
        test_reset_mid_ad_perm();
        test_busy_start_spurious();
`ifdef ASCON_DECRYPT_EN
        test_decrypt();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
